// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch plus a single shared memory port.
//
// The memory port is time-shared. Outside DATA it presents pc as an
// instruction-fetch address, with read and write strobes both low. In DATA
// it carries one load or store for the execute stage. The memory is
// combinational and big-endian: Mem_Result is the 16-bit word at
// Mem_Address.
//
// Ports
//   clk, rest                 clock; asynchronous active-low reset
//   Mem_Address/Mem_Read/
//   Mem_Write/Write_Data      memory request (combinational from state)
//   Mem_Result                memory read data
//   dreq_valid/_write/_addr/
//   dreq_wdata                data-access request from execute
//   dreq_done/dreq_rdata      one-cycle completion pulse and load data
//   redirect/redirect_pc      branch/jump PC load (bit 0 dropped)
//   inst_valid/inst/inst_pc/
//   inst_ready                one-entry instruction buffer toward decode
//   fetch_fault               pc ran past the instruction region
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'd0,
  parameter logic [15:0] INST_LIMIT = 16'd1023
) (
  input  logic        clk,
  input  logic        rest,
  // memory port
  output logic [15:0] Mem_Address,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [15:0] Write_Data,
  input  logic [15:0] Mem_Result,
  // data request from execute
  input  logic        dreq_valid,
  input  logic        dreq_write,
  input  logic [15:0] dreq_addr,
  input  logic [15:0] dreq_wdata,
  output logic        dreq_done,
  output logic [15:0] dreq_rdata,
  // redirect
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  // instruction handshake
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  // The last word-aligned pc that may still be fetched. A fetch from any
  // pc above it would read past INST_LIMIT, so that fetch faults instead.
  localparam logic [15:0] FETCH_MAX = INST_LIMIT - 16'd1;

  logic [1:0]  state, state_nxt;
  logic [15:0] pc, pc_nxt;

  // Data request latched when it is accepted. These registers drive the
  // memory port for the single DATA cycle.
  logic [15:0] lat_addr;
  logic        lat_write;
  logic [15:0] lat_wdata;

  logic accept;     // data request taken at this edge
  logic fetch_ok;   // every fetch condition holds apart from the limit check
  logic limit_hit;  // fetch wanted, but pc is outside the region
  logic do_fetch;   // instruction actually captured at this edge

  // ---------------------------------------------------------------------
  // Memory port mux
  // ---------------------------------------------------------------------
  always_comb begin
    Mem_Address = pc;
    Mem_Read    = 1'b0;
    Mem_Write   = 1'b0;
    Write_Data  = 16'h0000;
    if (state == S_DATA) begin
      Mem_Address = lat_addr;
      Mem_Read    = !lat_write;
      Mem_Write   = lat_write;
      Write_Data  = lat_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Edge decisions
  // ---------------------------------------------------------------------
  always_comb begin
    // A request is not accepted during its own done cycle, so a requester
    // that is still holding dreq_valid there is not serviced twice.
    accept    = dreq_valid && !dreq_done && (state != S_DATA);
    // Priority order is redirect, then data accept, then fetch. A full
    // buffer can still take a fetch if decode drains it at the same edge.
    fetch_ok  = (state == S_FETCH) && !redirect && !accept &&
                (!inst_valid || inst_ready);
    limit_hit = fetch_ok && (pc > FETCH_MAX);
    do_fetch  = fetch_ok && !limit_hit;
  end

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = S_DATA;
    else if (redirect)
      state_nxt = S_FETCH;
    else if (state == S_DATA)
      // A data access that started in FAULT returns to FAULT.
      state_nxt = fetch_fault ? S_FAULT : S_FETCH;
    else if (limit_hit)
      state_nxt = S_FAULT;
  end

  always_comb begin
    pc_nxt = pc;
    if (redirect)
      pc_nxt = redirect_pc & 16'hFFFE;   // instructions are word aligned
    else if (do_fetch)
      pc_nxt = pc + 16'd2;               // wraps modulo 2^16
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      lat_addr    <= 16'h0000;
      lat_write   <= 1'b0;
      lat_wdata   <= 16'h0000;
      dreq_done   <= 1'b0;
      dreq_rdata  <= 16'h0000;
      inst_valid  <= 1'b0;
      inst        <= 16'h0000;
      inst_pc     <= 16'h0000;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;

      if (accept) begin
        lat_addr  <= dreq_addr;
        lat_write <= dreq_write;
        lat_wdata <= dreq_wdata;
      end

      // DATA always lasts exactly one cycle. Its closing edge raises done.
      dreq_done <= (state == S_DATA);
      if ((state == S_DATA) && !lat_write)
        dreq_rdata <= Mem_Result;

      if (redirect)
        inst_valid <= 1'b0;
      else if (do_fetch) begin
        inst_valid <= 1'b1;
        inst       <= Mem_Result;
        inst_pc    <= pc;
      end else if (inst_valid && inst_ready)
        inst_valid <= 1'b0;

      if (redirect)
        fetch_fault <= 1'b0;
      else if (limit_hit)
        fetch_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. The bench holds a byte-addressed, big-endian
// memory model. Expected instructions go into a scoreboard queue when the
// stimulus that causes them is driven, and are popped when decode sees them.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rest;
  logic [15:0] Mem_Address;
  logic        Mem_Read, Mem_Write;
  logic [15:0] Write_Data, Mem_Result;
  logic        dreq_valid, dreq_write;
  logic [15:0] dreq_addr, dreq_wdata;
  logic        dreq_done;
  logic [15:0] dreq_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst, inst_pc;
  logic        inst_ready;
  logic        fetch_fault;

  typedef struct packed { logic [15:0] inst; logic [15:0] pc; } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  assign Mem_Result = {mem[Mem_Address], mem[Mem_Address + 16'd1]};

  always @(posedge clk)
    if (Mem_Write) begin
      mem[Mem_Address]         = Write_Data[15:8];
      mem[Mem_Address + 16'd1] = Write_Data[7:0];
    end

  function automatic logic [15:0] word_at(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], mem[a1]};
  endfunction

  fetch_unit dut (
    .clk(clk), .rest(rest),
    .Mem_Address(Mem_Address), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Write_Data(Write_Data), .Mem_Result(Mem_Result),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_done(dreq_done), .dreq_rdata(dreq_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  task automatic test_reset();
    rest = 1'b0; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;
    dreq_valid = 1'b0; dreq_write = 1'b0; dreq_addr = 16'h0; dreq_wdata = 16'h0;
    repeat (2) @(negedge clk);
    n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    n_chk++; if (inst !== 16'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0000", inst); end
    n_chk++; if (inst_pc !== 16'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0000", inst_pc); end
    n_chk++; if (dreq_done !== 1'b0 || dreq_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_dreq: got %b/%h want 0/0000", dreq_done, dreq_rdata); end
    n_chk++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
    n_chk++; if (Mem_Read !== 1'b0 || Mem_Write !== 1'b0 || Mem_Address !== 16'h0) begin n_fail++; $display("FAIL reset_mem: got r%b w%b a%h want r0 w0 a0000", Mem_Read, Mem_Write, Mem_Address); end
  endtask

  // Release reset with decode always ready: one instruction every cycle.
  task automatic test_stream();
    logic [15:0] np;
    rest = 1'b1;
    sb.push_back('{16'h1234, 16'h0000});
    np = 16'h0002;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_chk++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, inst_valid); end
      if (sb.size() == 0) begin n_fail++; $display("FAIL stream_empty_sb[%0d]", k); end
      else begin
        e = sb.pop_front();
        n_chk++; if (inst !== e.inst || inst_pc !== e.pc) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h@%h want %h@%h", k, inst, inst_pc, e.inst, e.pc); end
      end
      if (k == 0) sb.push_back('{16'hABCD, np});
      else if (k < 7) sb.push_back('{word_at(np), np});
      np = np + 16'd2;
    end
  endtask

  // Hold decode off for 3 cycles while the instruction at 0x000E is shown.
  task automatic test_stall();
    inst_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 16'h000E || inst !== word_at(16'h000E)) begin n_fail++; $display("FAIL stall_hold: got v%b %h@%h want v1 %h@000e", inst_valid, inst, inst_pc, word_at(16'h000E)); end
      n_chk++; if (Mem_Read !== 1'b0 || Mem_Write !== 1'b0 || Mem_Address !== 16'h0010) begin n_fail++; $display("FAIL stall_mem: got r%b w%b a%h want r0 w0 a0010", Mem_Read, Mem_Write, Mem_Address); end
    end
    inst_ready = 1'b1;
    sb.push_back('{word_at(16'h0010), 16'h0010});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin n_fail++; $display("FAIL stall_resume: got v%b %h@%h want v1 %h@%h", inst_valid, inst, inst_pc, e.inst, e.pc); end
  endtask

  // Write BEEF to 0x0400 and read it back. Fetch resumes at 0x0012.
  task automatic test_data();
    dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 16'h0400; dreq_wdata = 16'hBEEF;
    @(negedge clk);
    n_chk++; if (Mem_Write !== 1'b1 || Mem_Read !== 1'b0 || Mem_Address !== 16'h0400 || Write_Data !== 16'hBEEF) begin n_fail++; $display("FAIL data_wr_port: got r%b w%b a%h d%h want r0 w1 a0400 dbeef", Mem_Read, Mem_Write, Mem_Address, Write_Data); end
    n_chk++; if (dreq_done !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL data_wr_cycle: got done%b v%b want 0 0", dreq_done, inst_valid); end
    @(negedge clk);
    n_chk++; if (dreq_done !== 1'b1 || Mem_Write !== 1'b0 || dreq_rdata !== 16'h0000) begin n_fail++; $display("FAIL data_wr_done: got done%b w%b rd%h want 1 0 0000", dreq_done, Mem_Write, dreq_rdata); end
    dreq_valid = 1'b0;
    sb.push_back('{word_at(16'h0012), 16'h0012});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if (dreq_done !== 1'b0 || inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin n_fail++; $display("FAIL data_resume: got done%b v%b %h@%h want 0 1 %h@%h", dreq_done, inst_valid, inst, inst_pc, e.inst, e.pc); end
    dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 16'h0400;
    @(negedge clk);
    n_chk++; if (Mem_Read !== 1'b1 || Mem_Write !== 1'b0 || Mem_Address !== 16'h0400) begin n_fail++; $display("FAIL data_rd_port: got r%b w%b a%h want r1 w0 a0400", Mem_Read, Mem_Write, Mem_Address); end
    // Keep dreq_valid high through the done cycle. It must be ignored there.
    sb.push_back('{word_at(16'h0014), 16'h0014});
    @(negedge clk);
    n_chk++; if (dreq_done !== 1'b1 || dreq_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL data_rd_done: got done%b rd%h want 1 beef", dreq_done, dreq_rdata); end
    @(negedge clk);
    dreq_valid = 1'b0;
    e = sb.pop_front();
    n_chk++; if (dreq_done !== 1'b0 || Mem_Read !== 1'b0 || inst_pc !== e.pc || inst !== e.inst) begin n_fail++; $display("FAIL data_done_ignore: got done%b r%b %h@%h want 0 0 %h@%h", dreq_done, Mem_Read, inst, inst_pc, e.inst, e.pc); end
  endtask

  // Redirect to an odd address while an instruction is buffered.
  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 16'h0011;
    @(negedge clk);
    n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_clear: got %b want 0", inst_valid); end
    redirect = 1'b0;
    sb.push_back('{word_at(16'h0010), 16'h0010});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst !== e.inst) begin n_fail++; $display("FAIL redir_target: got v%b %h@%h want v1 %h@%h", inst_valid, inst, inst_pc, e.inst, e.pc); end
  endtask

  // Run off the end of the instruction region, then do a load and recover.
  task automatic test_fault();
    redirect = 1'b1; redirect_pc = 16'h03FE;
    @(negedge clk);
    redirect = 1'b0;
    sb.push_back('{word_at(16'h03FE), 16'h03FE});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst !== e.inst || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_last_ok: got v%b %h@%h f%b want v1 %h@%h f0", inst_valid, inst, inst_pc, fetch_fault, e.inst, e.pc); end
    @(negedge clk);
    n_chk++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0 || Mem_Address !== 16'h0400) begin n_fail++; $display("FAIL fault_enter: got f%b v%b a%h want f1 v0 a0400", fetch_fault, inst_valid, Mem_Address); end
    @(negedge clk);
    n_chk++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL fault_hold: got f%b v%b want f1 v0", fetch_fault, inst_valid); end
    dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 16'h0000;
    @(negedge clk);
    n_chk++; if (Mem_Read !== 1'b1 || Mem_Address !== 16'h0000 || fetch_fault !== 1'b1) begin n_fail++; $display("FAIL fault_data_port: got r%b a%h f%b want r1 a0000 f1", Mem_Read, Mem_Address, fetch_fault); end
    @(negedge clk);
    dreq_valid = 1'b0;
    n_chk++; if (dreq_done !== 1'b1 || dreq_rdata !== 16'h1234) begin n_fail++; $display("FAIL fault_data_done: got done%b rd%h want 1 1234", dreq_done, dreq_rdata); end
    @(negedge clk);
    n_chk++; if (fetch_fault !== 1'b1 || inst_valid !== 1'b0 || Mem_Address !== 16'h0400) begin n_fail++; $display("FAIL fault_after_data: got f%b v%b a%h want f1 v0 a0400", fetch_fault, inst_valid, Mem_Address); end
    redirect = 1'b1; redirect_pc = 16'h0000;
    @(negedge clk);
    n_chk++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b want 0", fetch_fault); end
    redirect = 1'b0;
    sb.push_back('{16'h1234, 16'h0000});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst !== e.inst) begin n_fail++; $display("FAIL fault_recover: got v%b %h@%h want v1 %h@%h", inst_valid, inst, inst_pc, e.inst, e.pc); end
  endtask

  // Redirect during DATA: the store completes and the PC load also applies.
  task automatic test_redirect_in_data();
    dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 16'h0500; dreq_wdata = 16'h1357;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0020;
    @(negedge clk);
    redirect = 1'b0; dreq_valid = 1'b0;
    n_chk++; if (dreq_done !== 1'b1 || inst_valid !== 1'b0 || word_at(16'h0500) !== 16'h1357) begin n_fail++; $display("FAIL rdata_done: got done%b v%b mem%h want 1 0 1357", dreq_done, inst_valid, word_at(16'h0500)); end
    sb.push_back('{word_at(16'h0020), 16'h0020});
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if (inst_valid !== 1'b1 || inst_pc !== e.pc || inst !== e.inst) begin n_fail++; $display("FAIL rdata_target: got v%b %h@%h want v1 %h@%h", inst_valid, inst, inst_pc, e.inst, e.pc); end
  endtask

  // Assert reset in the middle of a DATA cycle.
  task automatic test_reset_mid_data();
    dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 16'h0002;
    @(negedge clk);
    n_chk++; if (Mem_Read !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got r%b want 1", Mem_Read); end
    #2 rest = 1'b0; dreq_valid = 1'b0; inst_ready = 1'b0;
    #1;
    n_chk++; if (Mem_Read !== 1'b0 || Mem_Write !== 1'b0 || Mem_Address !== 16'h0000 || dreq_done !== 1'b0 || dreq_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_mem: got r%b w%b a%h done%b rd%h want 0 0 0000 0 0000", Mem_Read, Mem_Write, Mem_Address, dreq_done, dreq_rdata); end
    n_chk++; if (inst_valid !== 1'b0 || inst !== 16'h0 || inst_pc !== 16'h0 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_mid_inst: got v%b %h@%h f%b want 0 0000@0000 0", inst_valid, inst, inst_pc, fetch_fault); end
    @(negedge clk);
    rest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++; if (dreq_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_nodone[%0d]: got %b want 0", k, dreq_done); end
    end
    n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || inst !== 16'h1234) begin n_fail++; $display("FAIL rst_mid_refetch: got v%b %h@%h want v1 1234@0000", inst_valid, inst, inst_pc); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hAB; mem[3] = 8'hCD;
    test_reset();
    test_stream();
    test_stall();
    test_data();
    test_redirect();
    test_fault();
    test_redirect_in_data();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
